mod_exp_seq: RTL
================

Name: mod_exp_seq

Overview:
- Left-to-right square-and-multiply exponentiation sequencer. Computes result = base^exp mod n.
- Sits directly downstream of the modular multiplier stage (the MM / mod_exp datapath).
- Issues one multiply request at a time, consumes each product and feeds it back as the next operand.
- Isolates exponent-bit control from the multiplier datapath, so the multiplier is exercised only through a start/done handshake.

Parameters:
- W, 32, operand width for base, exp, n, result and all multiplier operands.
- CW, 6, width of internal bit index / counters; must satisfy 2^CW > W.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; operands are sampled on this cycle when idle.
- base  in  W  exponentiation base.
- exp  in  W  exponent.
- n  in  W  modulus.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; result is valid from this cycle until the next accepted start.
- err  out  1  set with done when n == 0; cleared on the next accepted start.
- result  out  W  final value.
- mul_en  out  1  one-cycle pulse that starts a modular multiply.
- mul_a  out  W  multiplier operand A; held stable from mul_en until mul_done.
- mul_b  out  W  multiplier operand B; held stable from mul_en until mul_done.
- mul_n  out  W  modulus to the multiplier; equals the latched n.
- mul_res  in  W  product (A*B mod n); sampled only when mul_done = 1.
- mul_done  in  1  one-cycle completion pulse from the multiplier.

Behaviour:
- Reset (async, rstn = 0): state = IDLE. busy, done, err, mul_en = 0. result, mul_a, mul_b, mul_n = 0. All internal registers = 0.
- IDLE:
  - start = 1 latches base, exp and n, sets busy, sets acc = 1, clears err, then goes to SCAN.
  - start during any other state is ignored; no queuing.
- SCAN (1 cycle): a priority encoder finds msb = index of the highest set bit of exp.
  - n == 0 -> FIN with err = 1 and result = 0.
  - exp == 0 -> FIN with result = (n == 1) ? 0 : 1.
  - Otherwise i = msb, go to SQR.
- SQR: mul_a = acc, mul_b = acc, mul_en pulses for one cycle, go to SQR_W.
- SQR_W: wait for mul_done.
  - On mul_done: acc = mul_res.
  - exp[i] = 1 -> MUL.
  - exp[i] = 0 and i == 0 -> FIN.
  - exp[i] = 0 and i != 0 -> i = i - 1, go to SQR.
- MUL: mul_a = acc, mul_b = latched base, mul_en pulses for one cycle, go to MUL_W.
- MUL_W: on mul_done, acc = mul_res; i == 0 -> FIN, else i = i - 1 and go to SQR.
- FIN (1 cycle): result = acc (or the special-case value), done = 1, busy = 0. Next cycle returns to IDLE.
- Multiplier handshake rules:
  - Exactly one outstanding request at a time.
  - mul_done outside SQR_W / MUL_W is ignored.
  - mul_done in the same cycle as mul_en is not accepted; the earliest accepted completion is the cycle after mul_en.
  - Waiting is unbounded; there is no timeout.
- Operation count: (msb + 1) squarings + (popcount(exp) - 1) + 1 multiplies. The first squaring of 1 is intentionally not skipped.
- Latency: 2 cycles (SCAN, FIN) + per multiply (1 issue cycle + multiplier latency).
- Reset mid-operation: async abort to IDLE with reset values; no done pulse. A later mul_done from the multiplier is ignored.
- The base is not pre-reduced; the multiplier is responsible for reducing operands of n or greater.

Optional Feature:
- Macro MOD_EXP_SEQ_PERF_EN.
- Defined:
  - Adds output mul_cnt [15:0]: number of mul_en pulses issued for the current operation.
  - Cleared on accepted start and on reset; holds its value after done until the next start.
  - Saturates at 16'hFFFF.
- Not defined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Bench multiplier model with a programmable latency L (1..5 cycles), computing (a*b) mod n.
- base = 4, exp = 13, n = 497, L = 3 -> result = 445; done pulses once; err = 0; mul_cnt = 7 (4 squares + 3 multiplies).
- exp = 0: n = 497 -> result = 1; n = 1 -> result = 0. In both cases no mul_en pulse and done arrives 2 cycles after start.
- base = 600, exp = 1, n = 497 -> result = 103. Exactly 2 multiply requests, with mul_a/mul_b = (1,1) then (1,600).
- n = 0, base = 5, exp = 9 -> done with err = 1 and result = 0. Then start with n = 497 clears err.
- start pulsed while busy with different operands -> ignored; the first operation's result is unchanged. Spurious mul_done in IDLE -> no state change.
- rstn asserted during MUL_W -> all outputs 0 immediately. Late mul_done ignored. A fresh run base = 3, exp = 5, n = 7 -> result = 5.

Source files
------------

// File: rtl/mod_exp_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : mod_exp_seq
// Purpose : left-to-right square-and-multiply sequencer, result = base^exp mod n,
//           driving an external modular multiplier via a start/done handshake.
//           Optional mul_cnt output enabled by macro MOD_EXP_SEQ_PERF_EN.
// Revision: 1.0 - initial release
// ============================================================================
module mod_exp_seq #(
  parameter int W  = 32,
  parameter int CW = 6
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic [W-1:0] base,
  input  logic [W-1:0] exp,
  input  logic [W-1:0] n,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] result,
  output logic         mul_en,
  output logic [W-1:0] mul_a,
  output logic [W-1:0] mul_b,
  output logic [W-1:0] mul_n,
  input  logic [W-1:0] mul_res,
  input  logic         mul_done
`ifdef MOD_EXP_SEQ_PERF_EN
  ,
  output logic [15:0]  mul_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_SQR   = 3'd2,
    S_SQR_W = 3'd3,
    S_MUL   = 3'd4,
    S_MUL_W = 3'd5,
    S_FIN   = 3'd6
  } state_t;

  state_t        state_q;
  logic [W-1:0]  base_q, exp_q, n_q, acc_q, result_q, mul_a_q, mul_b_q;
  logic [CW-1:0] idx_q;
  logic          busy_q, done_q, err_q, mul_en_q;
  logic [CW-1:0] msb_d;
  logic          bit_d;

  always_comb begin
    msb_d = '0;
    bit_d = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (exp_q[i]) msb_d = CW'(i);
      if (idx_q == CW'(i)) bit_d = exp_q[i];
    end
  end

  // Operands are loaded on the transition into SQR/MUL so mul_en is visible
  // during the issue state and completions are only taken in the wait states.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      exp_q    <= '0;
      n_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      mul_en_q <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      mul_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            base_q  <= base;
            exp_q   <= exp;
            n_q     <= n;
            acc_q   <= W'(1);
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (n_q == '0) begin
            err_q    <= 1'b1;
            result_q <= '0;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_FIN;
          end else if (exp_q == '0) begin
            result_q <= (n_q == W'(1)) ? '0 : W'(1);
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_FIN;
          end else begin
            idx_q    <= msb_d;
            mul_a_q  <= acc_q;
            mul_b_q  <= acc_q;
            mul_en_q <= 1'b1;
            state_q  <= S_SQR;
          end
        end
        S_SQR:   state_q <= S_SQR_W;
        S_MUL:   state_q <= S_MUL_W;
        S_SQR_W: begin
          if (mul_done) begin
            acc_q <= mul_res;
            if (bit_d) begin
              mul_a_q  <= mul_res;
              mul_b_q  <= base_q;
              mul_en_q <= 1'b1;
              state_q  <= S_MUL;
            end else if (idx_q == '0) begin
              result_q <= mul_res;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= S_FIN;
            end else begin
              idx_q    <= idx_q - 1'b1;
              mul_a_q  <= mul_res;
              mul_b_q  <= mul_res;
              mul_en_q <= 1'b1;
              state_q  <= S_SQR;
            end
          end
        end
        S_MUL_W: begin
          if (mul_done) begin
            acc_q <= mul_res;
            if (idx_q == '0) begin
              result_q <= mul_res;
              done_q   <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= S_FIN;
            end else begin
              idx_q    <= idx_q - 1'b1;
              mul_a_q  <= mul_res;
              mul_b_q  <= mul_res;
              mul_en_q <= 1'b1;
              state_q  <= S_SQR;
            end
          end
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef MOD_EXP_SEQ_PERF_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (state_q == S_IDLE && start) begin
      cnt_q <= '0;
    end else if (mul_en_q && cnt_q != 16'hFFFF) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign mul_cnt = cnt_q;
`endif

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;
  assign mul_en = mul_en_q;
  assign mul_a  = mul_a_q;
  assign mul_b  = mul_b_q;
  assign mul_n  = n_q;

endmodule
`default_nettype wire
